// File: rtl/ctl_pkg.sv
// Types and helpers shared by the control unit.
// Bundles the datapath control outputs into one struct so the idle value
// lives in a single place.
`include "alpacacorn.vh"

package ctl_pkg;

   typedef logic [`OP_WIDTH-1:0] op_t;

   // Everything the control unit tells the datapath each cycle
   typedef struct packed {
      op_t                            aluop;
      logic                           a_reg_en;
      logic [`CTR_CARRYMUX_WIDTH-1:0] carrymux;
   } ctl_ctrl_t;

   // Datapath stays quiet: no accumulator load, carry untouched
   localparam ctl_ctrl_t CTRL_IDLE = '{
      aluop:    `OP_STA,
      a_reg_en: 1'b0,
      carrymux: `CARRY_OP_KEEP
   };

   // Only JCC executes without an operand memory access
   function automatic logic op_uses_mem(input op_t op);
      return (op != `OP_JCC);
   endfunction

endpackage

// File: rtl/alpacacorn.vh
// Shared constants for the alpacacorn accumulator CPU: ALU opcodes, carry-mux
// selects and control-unit state encodings. Included by every core file that
// needs them; the guard makes repeated inclusion harmless.
`ifndef ALPACACORN_VH
`define ALPACACORN_VH

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

// ALU opcodes double as the instruction opcodes in IR[DATA_WIDTH-1 -: 2]
`define OP_WIDTH 2
`define OP_NOR 2'b00
`define OP_ADD 2'b01
`define OP_STA 2'b10
`define OP_JCC 2'b11

// Carry flag update select presented to the datapath
`define CTR_CARRYMUX_WIDTH 2
`define CARRY_OP_KEEP 2'b00
`define CARRY_OP_GEN  2'b01
`define CARRY_OP_CLR  2'b10

// Control-unit FSM encodings
`define CTL_STATE_WIDTH 2
`define CTL_ST_FETCH 2'b00
`define CTL_ST_EXEC  2'b01
`define CTL_ST_HALT  2'b10

`endif

// File: rtl/ctl.sv
// Control unit for the accumulator CPU: owns PC/IR, sequences fetch and
// execute over a req/ack memory port, drives the datapath controls.
// Optional build macro CTL_HALT_EN adds halt_o and a HALT state for self-jumps.
`include "alpacacorn.vh"

module ctl
   import ctl_pkg::*;
#(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int ADDR_WIDTH = DATA_WIDTH - 2
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   output logic                           mem_req_o,
   output logic                           mem_we_o,
   output logic [ADDR_WIDTH-1:0]          mem_addr_o,
   input  logic                           mem_ack_i,
   input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
   input  logic                           carry_i,
   output logic [`OP_WIDTH-1:0]           ctr_aluop_o,
   output logic                           ctr_a_reg_en_o,
   output logic [`CTR_CARRYMUX_WIDTH-1:0] ctr_carrymux_o
`ifdef CTL_HALT_EN
   ,
   output logic                           halt_o
`endif
);

   localparam logic [`CTL_STATE_WIDTH-1:0] ST_FETCH = `CTL_ST_FETCH;
   localparam logic [`CTL_STATE_WIDTH-1:0] ST_EXEC  = `CTL_ST_EXEC;
`ifdef CTL_HALT_EN
   localparam logic [`CTL_STATE_WIDTH-1:0] ST_HALT  = `CTL_ST_HALT;
`endif

   localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [`CTL_STATE_WIDTH-1:0] state, state_nxt;
   logic [ADDR_WIDTH-1:0]       pc, pc_nxt;
   logic [DATA_WIDTH-1:0]       ir, ir_nxt;

   op_t                   ir_op;
   logic [ADDR_WIDTH-1:0] ir_addr;

   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   ctl_ctrl_t             ctrl;
   logic                  halt;
   logic                  xfer;

   assign ir_op   = ir[DATA_WIDTH-1 -: `OP_WIDTH];
   assign ir_addr = ir[ADDR_WIDTH-1:0];

   // An ack only counts while we are actually requesting; req is held low
   // during reset, so a stray ack in reset can never complete anything.
   assign xfer = req & mem_ack_i;

   // Output decode: memory port and datapath controls from state and IR
   always_comb begin
      req  = 1'b0;
      we   = 1'b0;
      addr = '0;
      ctrl = CTRL_IDLE;
      halt = 1'b0;
      if (!rst_i) begin
         case (state)
            ST_FETCH: begin
               req  = 1'b1;
               addr = pc;
            end
            ST_EXEC: begin
               if (op_uses_mem(ir_op)) begin
                  req  = 1'b1;
                  addr = ir_addr;
                  we   = (ir_op == `OP_STA);
               end
               case (ir_op)
                  `OP_NOR: begin
                     ctrl.aluop = `OP_NOR;
                     // Load the accumulator only in the cycle the operand arrives
                     ctrl.a_reg_en = xfer;
                  end
                  `OP_ADD: begin
                     ctrl.aluop = `OP_ADD;
                     ctrl.a_reg_en = xfer;
                     if (xfer) begin
                        ctrl.carrymux = `CARRY_OP_GEN;
                     end
                  end
                  `OP_JCC: begin
                     ctrl.aluop    = `OP_JCC;
                     ctrl.carrymux = `CARRY_OP_CLR;
                  end
                  default: begin
                     // STA: write data is the accumulator, wired outside
                  end
               endcase
            end
`ifdef CTL_HALT_EN
            ST_HALT: begin
               halt = 1'b1;
            end
`endif
            default: begin
               // Illegal encoding: stay idle for the one cycle it takes to recover
            end
         endcase
      end
   end

   // Next-state, PC and IR update
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      ir_nxt    = ir;
      case (state)
         ST_FETCH: begin
            if (xfer) begin
               ir_nxt    = mem_rdata_i;
               pc_nxt    = pc + PC_ONE;
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (ir_op == `OP_JCC) begin
               // Single-cycle branch on a clear carry
               state_nxt = ST_FETCH;
               if (!carry_i) begin
                  pc_nxt = ir_addr;
`ifdef CTL_HALT_EN
                  // PC already points past the JCC, so PC-1 is its own address
                  if (ir_addr == (pc - PC_ONE)) begin
                     state_nxt = ST_HALT;
                  end
`endif
               end
            end else if (xfer) begin
               state_nxt = ST_FETCH;
            end
         end
`ifdef CTL_HALT_EN
         ST_HALT: begin
            state_nxt = ST_HALT;
         end
`endif
         default: begin
            state_nxt = ST_FETCH;
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_FETCH;
         pc    <= '0;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         ir    <= ir_nxt;
      end
   end

   assign mem_req_o      = req;
   assign mem_we_o       = we;
   assign mem_addr_o     = addr;
   assign ctr_aluop_o    = ctrl.aluop;
   assign ctr_a_reg_en_o = ctrl.a_reg_en;
   assign ctr_carrymux_o = ctrl.carrymux;
`ifdef CTL_HALT_EN
   assign halt_o         = halt;
`else
   // Without the halt feature the HALT state does not exist
   logic unused_halt;
   assign unused_halt = halt;
`endif

endmodule

// File: tb/tb_ctl.sv
// Self-checking bench for ctl: directed scenarios plus a random program
// compared against an instruction-level model of fetch/execute bus traffic.
// Also exercises the CTL_HALT_EN build when that macro is defined.
module tb_ctl;

   localparam logic [1:0] A_NOR = 2'b00;
   localparam logic [1:0] A_ADD = 2'b01;
   localparam logic [1:0] A_STA = 2'b10;
   localparam logic [1:0] A_JCC = 2'b11;
   localparam logic [1:0] CM_KEEP = 2'b00;
   localparam logic [1:0] CM_GEN  = 2'b01;
   localparam logic [1:0] CM_CLR  = 2'b10;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       mem_ack_i = 1'b0;
   logic       carry_i = 1'b0;
   logic [7:0] mem_rdata_i = 8'h00;
   logic       mem_req_o;
   logic       mem_we_o;
   logic [5:0] mem_addr_o;
   logic [1:0] ctr_aluop_o;
   logic       ctr_a_reg_en_o;
   logic [1:0] ctr_carrymux_o;
`ifdef CTL_HALT_EN
   logic       halt_o;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] mem [64];

   always #5 clk = ~clk;

   ctl #(.DATA_WIDTH(8)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_addr_o     (mem_addr_o),
      .mem_ack_i      (mem_ack_i),
      .mem_rdata_i    (mem_rdata_i),
      .carry_i        (carry_i),
      .ctr_aluop_o    (ctr_aluop_o),
      .ctr_a_reg_en_o (ctr_a_reg_en_o),
      .ctr_carrymux_o (ctr_carrymux_o)
`ifdef CTL_HALT_EN
      ,
      .halt_o         (halt_o)
`endif
   );

   // Packs a bus/control snapshot; we and addr only matter while req is high
   function automatic logic [12:0] pack(input logic req, input logic we,
                                        input logic [5:0] addr, input logic [1:0] op,
                                        input logic en, input logic [1:0] cm);
      return {req, req & we, req ? addr : 6'd0, op, en, cm};
   endfunction

   // One clock: drive inputs at the falling edge, sample just after, then let the edge pass
   task automatic cycle(input logic rst, input logic ack, input logic carry,
                        output logic [12:0] obs, output logic hlt);
      @(negedge clk);
      rst_i       = rst;
      mem_ack_i   = ack;
      carry_i     = carry;
      mem_rdata_i = mem[mem_addr_o];
      #1;
      obs = pack(mem_req_o, mem_we_o, mem_addr_o, ctr_aluop_o, ctr_a_reg_en_o, ctr_carrymux_o);
`ifdef CTL_HALT_EN
      hlt = halt_o;
`else
      hlt = 1'b0;
`endif
      @(posedge clk);
   endtask

   task automatic do_reset();
      logic [12:0] o;
      logic h;
      cycle(1'b1, 1'b0, 1'b0, o, h);
      cycle(1'b1, 1'b0, 1'b0, o, h);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
   endtask

   task automatic test_reset();
      logic [12:0] o, e;
      logic h;
      clear_mem();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1, 1'b0, o, h);
         e = pack(1'b0, 1'b0, 6'd0, A_STA, 1'b0, CM_KEEP);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL reset_hold[%0d]: got %h want %h", i, o, e);
         end
`ifdef CTL_HALT_EN
         vectors++;
         if (h !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_halt[%0d]: got %b want 0", i, h);
         end
`endif
      end
      cycle(1'b0, 1'b0, 1'b0, o, h);
      e = pack(1'b1, 1'b0, 6'h00, A_STA, 1'b0, CM_KEEP);
      vectors++;
      if (o !== e) begin
         miscompares++;
         $display("FAIL reset_release: got %h want %h", o, e);
      end
   endtask

   task automatic test_add();
      logic [12:0] o, e;
      logic h;
      clear_mem();
      mem[0]    = 8'h4A;
      mem[6'hA] = 8'h05;
      do_reset();
      cycle(1'b0, 1'b1, 1'b0, o, h);
      e = pack(1'b1, 1'b0, 6'h00, A_STA, 1'b0, CM_KEEP);
      vectors++;
      if (o !== e) begin
         miscompares++;
         $display("FAIL add_fetch: got %h want %h", o, e);
      end
      cycle(1'b0, 1'b1, 1'b0, o, h);
      e = pack(1'b1, 1'b0, 6'h0A, A_ADD, 1'b1, CM_GEN);
      vectors++;
      if (o !== e) begin
         miscompares++;
         $display("FAIL add_exec: got %h want %h", o, e);
      end
      cycle(1'b0, 1'b0, 1'b0, o, h);
      e = pack(1'b1, 1'b0, 6'h01, A_STA, 1'b0, CM_KEEP);
      vectors++;
      if (o !== e) begin
         miscompares++;
         $display("FAIL add_next_fetch: got %h want %h", o, e);
      end
   endtask

   task automatic test_jcc();
      logic [12:0] o, e;
      logic h;
      for (int c = 0; c < 2; c++) begin
         clear_mem();
         mem[0] = 8'hC5;
         do_reset();
         cycle(1'b0, 1'b1, 1'(c), o, h);
         e = pack(1'b1, 1'b0, 6'h00, A_STA, 1'b0, CM_KEEP);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL jcc_fetch c=%0d: got %h want %h", c, o, e);
         end
         // ack offered with no request must be ignored
         cycle(1'b0, 1'b1, 1'(c), o, h);
         e = pack(1'b0, 1'b0, 6'h00, A_JCC, 1'b0, CM_CLR);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL jcc_exec c=%0d: got %h want %h", c, o, e);
         end
         cycle(1'b0, 1'b0, 1'(c), o, h);
         e = pack(1'b1, 1'b0, (c == 0) ? 6'h05 : 6'h01, A_STA, 1'b0, CM_KEEP);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL jcc_target c=%0d: got %h want %h", c, o, e);
         end
      end
   endtask

   task automatic test_sta_wait();
      logic [12:0] o, e;
      logic h;
      clear_mem();
      mem[0] = 8'h8C;
      do_reset();
      cycle(1'b0, 1'b1, 1'b0, o, h);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, (i == 3), 1'b0, o, h);
         e = pack(1'b1, 1'b1, 6'h0C, A_STA, 1'b0, CM_KEEP);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL sta_wait[%0d]: got %h want %h", i, o, e);
         end
      end
      cycle(1'b0, 1'b0, 1'b0, o, h);
      e = pack(1'b1, 1'b0, 6'h01, A_STA, 1'b0, CM_KEEP);
      vectors++;
      if (o !== e) begin
         miscompares++;
         $display("FAIL sta_next_fetch: got %h want %h", o, e);
      end
   endtask

   task automatic test_nor_wrap();
      logic [12:0] o, e;
      logic h;
      clear_mem();
      mem[0]     = 8'hFF;   // JCC 0x3F
      mem[6'h3F] = 8'h10;   // NOR 0x10
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         cycle(1'b0, 1'b1, 1'b0, o, h);
         cycle(1'b0, 1'b0, 1'b0, o, h);
         cycle(1'b0, 1'b1, 1'b0, o, h);
         e = pack(1'b1, 1'b0, 6'h3F, A_STA, 1'b0, CM_KEEP);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL nor_fetch_3f p=%0d: got %h want %h", pass, o, e);
         end
         if (pass == 0) begin
            for (int i = 0; i < 3; i++) begin
               cycle(1'b0, (i == 2), 1'b0, o, h);
               e = pack(1'b1, 1'b0, 6'h10, A_NOR, (i == 2), CM_KEEP);
               vectors++;
               if (o !== e) begin
                  miscompares++;
                  $display("FAIL nor_wait[%0d]: got %h want %h", i, o, e);
               end
            end
            cycle(1'b0, 1'b0, 1'b0, o, h);
            e = pack(1'b1, 1'b0, 6'h00, A_STA, 1'b0, CM_KEEP);
            vectors++;
            if (o !== e) begin
               miscompares++;
               $display("FAIL nor_pc_wrap: got %h want %h", o, e);
            end
         end else begin
            cycle(1'b0, 1'b0, 1'b0, o, h);
            cycle(1'b1, 1'b1, 1'b0, o, h);
            e = pack(1'b0, 1'b0, 6'h00, A_STA, 1'b0, CM_KEEP);
            vectors++;
            if (o !== e) begin
               miscompares++;
               $display("FAIL nor_abort_reset: got %h want %h", o, e);
            end
            cycle(1'b0, 1'b0, 1'b0, o, h);
            e = pack(1'b1, 1'b0, 6'h00, A_STA, 1'b0, CM_KEEP);
            vectors++;
            if (o !== e) begin
               miscompares++;
               $display("FAIL nor_abort_restart: got %h want %h", o, e);
            end
         end
      end
   endtask

   task automatic test_halt();
      logic [12:0] o, e;
      logic h;
      clear_mem();
      mem[0] = 8'h01;
      mem[1] = 8'h02;
      mem[2] = 8'h03;
      mem[3] = 8'hC3;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 1'b1, 1'b0, o, h);
         cycle(1'b0, 1'b1, 1'b0, o, h);
         e = pack(1'b1, 1'b0, 6'(k + 1), A_NOR, 1'b1, CM_KEEP);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL halt_prog_nor[%0d]: got %h want %h", k, o, e);
         end
      end
`ifdef CTL_HALT_EN
      cycle(1'b0, 1'b1, 1'b0, o, h);
      cycle(1'b0, 1'b0, 1'b0, o, h);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 1'b1, 1'b0, o, h);
         e = pack(1'b0, 1'b0, 6'h00, A_STA, 1'b0, CM_KEEP);
         vectors++;
         if (o !== e || h !== 1'b1) begin
            miscompares++;
            $display("FAIL halted[%0d]: got %h halt=%b want %h halt=1", i, o, h, e);
         end
      end
      cycle(1'b1, 1'b0, 1'b0, o, h);
      vectors++;
      if (h !== 1'b0) begin
         miscompares++;
         $display("FAIL halt_reset_clear: got %b want 0", h);
      end
      cycle(1'b0, 1'b0, 1'b0, o, h);
      e = pack(1'b1, 1'b0, 6'h00, A_STA, 1'b0, CM_KEEP);
      vectors++;
      if (o !== e || h !== 1'b0) begin
         miscompares++;
         $display("FAIL halt_restart: got %h halt=%b want %h halt=0", o, h, e);
      end
`else
      for (int r = 0; r < 3; r++) begin
         cycle(1'b0, 1'b1, 1'b0, o, h);
         e = pack(1'b1, 1'b0, 6'h03, A_STA, 1'b0, CM_KEEP);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL selfjump_fetch[%0d]: got %h want %h", r, o, e);
         end
         cycle(1'b0, 1'b0, 1'b0, o, h);
         e = pack(1'b0, 1'b0, 6'h00, A_JCC, 1'b0, CM_CLR);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL selfjump_exec[%0d]: got %h want %h", r, o, e);
         end
      end
`endif
   endtask

   // Random program run against an instruction-level model of the bus traffic
   task automatic test_random();
      logic [12:0] o, e;
      logic h;
      logic [5:0] pc;
      logic [7:0] ins;
      logic [1:0] op;
      logic [5:0] tgt;
      logic c, ack;
      int w;
      for (int i = 0; i < 64; i++) begin
         mem[i] = 8'($urandom_range(0, 255));
         // keep self-jumps out so halting cannot stop the program
         if (mem[i][7:6] == 2'b11 && mem[i][5:0] == 6'(i)) mem[i][5:0] = 6'(i + 2);
      end
      pc = 6'h00;
      do_reset();
      for (int n = 0; n < 200; n++) begin
         w = int'($urandom_range(0, 2));
         for (int j = 0; j <= w; j++) begin
            cycle(1'b0, (j == w), 1'($urandom_range(0, 1)), o, h);
            e = pack(1'b1, 1'b0, pc, A_STA, 1'b0, CM_KEEP);
            vectors++;
            if (o !== e) begin
               miscompares++;
               $display("FAIL rnd_fetch n=%0d: got %h want %h", n, o, e);
            end
         end
         ins = mem[pc];
         pc  = pc + 6'd1;
         op  = ins[7:6];
         tgt = ins[5:0];
         if (op == A_JCC) begin
            c = 1'($urandom_range(0, 1));
            cycle(1'b0, 1'($urandom_range(0, 1)), c, o, h);
            e = pack(1'b0, 1'b0, 6'h00, A_JCC, 1'b0, CM_CLR);
            vectors++;
            if (o !== e) begin
               miscompares++;
               $display("FAIL rnd_jcc n=%0d: got %h want %h", n, o, e);
            end
            if (!c) pc = tgt;
         end else begin
            w = int'($urandom_range(0, 3));
            for (int j = 0; j <= w; j++) begin
               ack = (j == w);
               cycle(1'b0, ack, 1'($urandom_range(0, 1)), o, h);
               e = pack(1'b1, (op == A_STA), tgt, op, ack && (op != A_STA),
                        (ack && op == A_ADD) ? CM_GEN : CM_KEEP);
               vectors++;
               if (o !== e) begin
                  miscompares++;
                  $display("FAIL rnd_exec n=%0d op=%0d: got %h want %h", n, op, o, e);
               end
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_add();
      test_jcc();
      test_sta_wait();
      test_nor_wrap();
      test_halt();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
